// File: rtl/mbc1_bank_ctrl.sv
// MBC1-style cartridge bank controller: synchronises the async cartridge bus,
// decodes CPU writes to 0x0000-0x7FFF into bank registers and produces the
// banked ROM byte address plus a qualified ROM read-select.
module mbc1_bank_ctrl #(
   parameter int unsigned ROM_ADDR_W = 21,
   parameter int unsigned MIN_LOW    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           address,
   input  logic [7:0]            data_in,
   input  logic                  nWR,
   input  logic                  nRD,
   input  logic                  nCS,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   output logic                  rom_sel,
   output logic                  ram_enable,
   output logic [1:0]            ram_bank,
   output logic                  bank_mode,
   output logic                  wr_commit
);

   localparam int unsigned CNT_W = $clog2(MIN_LOW + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_LOW);

   typedef enum logic [1:0] {
      StIdle,
      StLow,
      StCommit
   } state_e;

   // Two-flop synchronisers
   logic [15:0] r_addr_s1, r_addr_s2;
   logic [7:0]  r_data_s1, r_data_s2;
   logic        r_nwr_s1, r_nwr_s2;
   logic        r_nrd_s1, r_nrd_s2;
   logic        r_ncs_s1, r_ncs_s2;

   // Write FSM and bank registers
   state_e          r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]      r_cap_addr;   // captured address[15:13]
   logic [7:0]      r_cap_data;
   logic [4:0]      r_bank_lo;
   logic [1:0]      r_bank_hi;
   logic            r_mode;
   logic            r_ram_en;
   logic            r_wr_commit;

   // Output registers
   logic [ROM_ADDR_W-1:0] r_rom_addr;
   logic                  r_rom_sel;

   logic [20:0]            w_rom_full;
   logic [ROM_ADDR_W+20:0] w_rom_ext;
   logic                   w_unused;

   // Synchronise every bus input; strobes idle high, address/data idle zero
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr_s1 <= '0;
         r_addr_s2 <= '0;
         r_data_s1 <= '0;
         r_data_s2 <= '0;
         r_nwr_s1  <= 1'b1;
         r_nwr_s2  <= 1'b1;
         r_nrd_s1  <= 1'b1;
         r_nrd_s2  <= 1'b1;
         r_ncs_s1  <= 1'b1;
         r_ncs_s2  <= 1'b1;
      end else begin
         r_addr_s1 <= address;
         r_addr_s2 <= r_addr_s1;
         r_data_s1 <= data_in;
         r_data_s2 <= r_data_s1;
         r_nwr_s1  <= nWR;
         r_nwr_s2  <= r_nwr_s1;
         r_nrd_s1  <= nRD;
         r_nrd_s2  <= r_nrd_s1;
         r_ncs_s1  <= nCS;
         r_ncs_s2  <= r_ncs_s1;
      end
   end

   // Write FSM: qualify nWR low width, capture bus at trailing edge, apply on commit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_cap_addr  <= '0;
         r_cap_data  <= '0;
         r_bank_lo   <= 5'd1;
         r_bank_hi   <= 2'd0;
         r_mode      <= 1'b0;
         r_ram_en    <= 1'b0;
         r_wr_commit <= 1'b0;
      end else begin
         r_wr_commit <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (!r_nwr_s2) begin
                  r_state    <= StLow;
                  r_cnt      <= CNT_W'(1);
                  r_cap_addr <= r_addr_s2[15:13];
                  r_cap_data <= r_data_s2;
               end
            end
            StLow: begin
               if (!r_nwr_s2) begin
                  // Keep re-capturing so the last low cycle's values win
                  r_cap_addr <= r_addr_s2[15:13];
                  r_cap_data <= r_data_s2;
                  if (r_cnt < CNT_MAX) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end else if ((r_cnt >= CNT_MAX) && r_ncs_s2 && !r_cap_addr[2]) begin
                  r_state <= StCommit;
               end else begin
                  r_state <= StIdle;
               end
            end
            StCommit: begin
               r_wr_commit <= 1'b1;
               r_state     <= StIdle;
               unique case (r_cap_addr[1:0])
                  2'b00: r_ram_en  <= (r_cap_data[3:0] == 4'hA);
                  2'b01: r_bank_lo <= (r_cap_data[4:0] == 5'd0) ? 5'd1 : r_cap_data[4:0];
                  2'b10: r_bank_hi <= r_cap_data[1:0];
                  2'b11: r_mode    <= r_cap_data[0];
                  default: r_mode  <= r_mode;
               endcase
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Banked ROM address from the synchronised CPU address
   always_comb begin
      w_rom_full = '0;
      if (r_addr_s2[14]) begin
         w_rom_full = {r_bank_hi, r_bank_lo, r_addr_s2[13:0]};
      end else begin
         w_rom_full = {(r_mode ? r_bank_hi : 2'b00), 5'b00000, r_addr_s2[13:0]};
      end
   end

   // Zero-extend then truncate so any ROM_ADDR_W works; upper bits wrap away
   assign w_rom_ext = {{ROM_ADDR_W{1'b0}}, w_rom_full};

   // Register the ROM address and read qualifier
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rom_addr <= '0;
         r_rom_sel  <= 1'b0;
      end else begin
         r_rom_addr <= w_rom_ext[ROM_ADDR_W-1:0];
         r_rom_sel  <= ~r_addr_s2[15] & ~r_nrd_s2 & r_nwr_s2 & r_ncs_s2;
      end
   end

   assign w_unused = ^{r_cap_data[7:5], w_rom_ext[ROM_ADDR_W+20:ROM_ADDR_W]};

   assign rom_addr   = r_rom_addr;
   assign rom_sel    = r_rom_sel;
   assign ram_enable = r_ram_en;
   assign ram_bank   = r_mode ? r_bank_hi : 2'b00;
   assign bank_mode  = r_mode;
   assign wr_commit  = r_wr_commit;

endmodule

// File: tb/tb_mbc1_bank_ctrl.sv
// Scoreboard bench for mbc1_bank_ctrl: stimulus pushes expected commits/reads,
// a negedge monitor pops and compares whenever wr_commit pulses or rom_sel rises.
module tb_mbc1_bank_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] address;
   logic [7:0]  data_in;
   logic        nWR;
   logic        nRD;
   logic        nCS;
   logic [20:0] rom_addr;
   logic        rom_sel;
   logic        ram_enable;
   logic [1:0]  ram_bank;
   logic        bank_mode;
   logic        wr_commit;

   mbc1_bank_ctrl #(
      .ROM_ADDR_W(21),
      .MIN_LOW   (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .address   (address),
      .data_in   (data_in),
      .nWR       (nWR),
      .nRD       (nRD),
      .nCS       (nCS),
      .rom_addr  (rom_addr),
      .rom_sel   (rom_sel),
      .ram_enable(ram_enable),
      .ram_bank  (ram_bank),
      .bank_mode (bank_mode),
      .wr_commit (wr_commit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [20:0] addr;
      logic        en;
      logic [1:0]  rb;
      logic        md;
      int          cyc;
   } rd_exp_t;

   typedef struct {
      logic       en;
      logic [1:0] rb;
      logic       md;
      int         cyc;
   } wr_exp_t;

   rd_exp_t rd_q[$];
   wr_exp_t wr_q[$];
   rd_exp_t re;
   wr_exp_t we;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic prev_sel = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation each time the DUT presents a result
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_commit) begin
            if (wr_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_commit: got pulse at cycle %0d expected none", cyc);
            end else begin
               we = wr_q.pop_front();
               chk("commit_latency", cyc - we.cyc, 4);
               chk("commit_ram_enable", {31'd0, ram_enable}, {31'd0, we.en});
               chk("commit_ram_bank", {30'd0, ram_bank}, {30'd0, we.rb});
               chk("commit_bank_mode", {31'd0, bank_mode}, {31'd0, we.md});
            end
         end
         if (rom_sel && !prev_sel) begin
            if (rd_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rom_sel: got rise at cycle %0d expected none", cyc);
            end else begin
               re = rd_q.pop_front();
               chk("read_latency", cyc - re.cyc, 3);
               chk("read_rom_addr", {11'd0, rom_addr}, {11'd0, re.addr});
               chk("read_ram_enable", {31'd0, ram_enable}, {31'd0, re.en});
               chk("read_ram_bank", {30'd0, ram_bank}, {30'd0, re.rb});
               chk("read_bank_mode", {31'd0, bank_mode}, {31'd0, re.md});
            end
         end
      end
      prev_sel = rom_sel;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while ((rd_q.size() != 0 || wr_q.size() != 0) && t < 30) begin
         tick(1);
         t++;
      end
      total++;
      if (rd_q.size() != 0 || wr_q.size() != 0) begin
         bad++;
         $display("FAIL %s_timeout: got %0d pending expected 0", name, rd_q.size() + wr_q.size());
         rd_q.delete();
         wr_q.delete();
      end
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int low,
                           input logic cs, input logic exp_c, input logic en,
                           input logic [1:0] rb, input logic md);
      wr_exp_t e;
      address = a;
      data_in = d;
      nCS     = cs;
      nRD     = 1'b1;
      tick(1);
      nWR = 1'b0;
      tick(low);
      if (exp_c) begin
         e.en = en; e.rb = rb; e.md = md; e.cyc = cyc;
         wr_q.push_back(e);
      end
      nWR = 1'b1;
      tick(8);
      nCS = 1'b1;
      drain("write");
   endtask

   task automatic do_read(input logic [15:0] a, input logic [20:0] ea, input logic en,
                          input logic [1:0] rb, input logic md);
      rd_exp_t e;
      address = a;
      nRD     = 1'b0;
      e.addr = ea; e.en = en; e.rb = rb; e.md = md; e.cyc = cyc;
      rd_q.push_back(e);
      tick(6);
      drain("read");
      nRD = 1'b1;
      tick(4);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_rom_addr", {11'd0, rom_addr}, 32'd0);
      chk("rst_rom_sel", {31'd0, rom_sel}, 32'd0);
      chk("rst_ram_enable", {31'd0, ram_enable}, 32'd0);
      chk("rst_ram_bank", {30'd0, ram_bank}, 32'd0);
      chk("rst_bank_mode", {31'd0, bank_mode}, 32'd0);
      chk("rst_wr_commit", {31'd0, wr_commit}, 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; address = '0; data_in = '0; nWR = 1'b1; nRD = 1'b1; nCS = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk_reset_outputs();
      tick(3);

      // Reset defaults: bank 1
      do_read(16'h4123, 21'h04123, 1'b0, 2'd0, 1'b0);

      // Bank select, including the zero-maps-to-one cases
      do_write(16'h2000, 8'h05, 40, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      do_read(16'h4000, 21'h14000, 1'b0, 2'd0, 1'b0);
      do_write(16'h2000, 8'h00, 40, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      do_read(16'h4000, 21'h04000, 1'b0, 2'd0, 1'b0);
      do_write(16'h2000, 8'h1F, 40, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      do_read(16'h4000, 21'h7C000, 1'b0, 2'd0, 1'b0);
      do_write(16'h2000, 8'h20, 40, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      do_read(16'h4000, 21'h04000, 1'b0, 2'd0, 1'b0);

      // Upper bits and mode
      do_write(16'h4000, 8'h02, 40, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      do_write(16'h6000, 8'h01, 40, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
      do_read(16'h0010, 21'h100010, 1'b0, 2'd2, 1'b1);
      do_read(16'h4000, 21'h104000, 1'b0, 2'd2, 1'b1);
      do_write(16'h6000, 8'h00, 40, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      do_read(16'h0010, 21'h000010, 1'b0, 2'd0, 1'b0);
      do_read(16'h4000, 21'h104000, 1'b0, 2'd0, 1'b0);

      // RAM enable
      do_write(16'h0000, 8'h0A, 40, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
      do_read(16'h0010, 21'h000010, 1'b1, 2'd0, 1'b0);
      do_write(16'h0000, 8'h1B, 40, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      do_write(16'h0000, 8'h0A, 40, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);

      // Ignored writes: short pulses, high address, nCS low
      do_write(16'h2000, 8'h03, 2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      do_write(16'h2000, 8'h03, 3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      do_write(16'hA000, 8'h03, 40, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      do_write(16'h2000, 8'h03, 40, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      do_read(16'h4000, 21'h104000, 1'b1, 2'd0, 1'b0);

      // Minimum qualifying pulse width
      do_write(16'h2000, 8'h03, 4, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
      do_read(16'h4000, 21'h10C000, 1'b1, 2'd0, 1'b0);

      // Reset mid-write discards the write
      address = 16'h2000; data_in = 8'h07; nCS = 1'b1; nRD = 1'b1;
      tick(1);
      nWR = 1'b0;
      tick(10);
      rst = 1'b1;
      nWR = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk_reset_outputs();
      tick(8);
      do_read(16'h4000, 21'h04000, 1'b0, 2'd0, 1'b0);

      // FSM is back in idle: a normal write still works
      do_write(16'h2000, 8'h02, 40, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      do_read(16'h4000, 21'h08000, 1'b0, 2'd0, 1'b0);

      tick(5);
      total++;
      if (rd_q.size() != 0 || wr_q.size() != 0) begin
         bad++;
         $display("FAIL final_queues: got %0d pending expected 0", rd_q.size() + wr_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mbc1_bank_ctrl.md
# mbc1_bank_ctrl

MBC1-style bank controller for the Game Boy FPGA cartridge. Sits directly upstream of the ROM read stage: it synchronises the asynchronous cartridge bus into the 100 MHz `clk` domain and decodes CPU writes to 0x0000–0x7FFF into bank registers. It drives the banked ROM byte address and a qualified read-select, so the read stage can index a ROM larger than 32 KiB.

## Interface

Parameters:
- `ROM_ADDR_W`, 21: width of `rom_addr`; upper bits of the computed address are dropped, so banks wrap modulo ROM size.
- `MIN_LOW`, 4: minimum consecutive synchronised-low `nWR` cycles for a write to count.

Ports (one clock; reset is synchronous and active-high):
- `clk`, input, 1: 100 MHz FPGA clock.
- `rst`, input, 1: synchronous active-high reset.
- `address`, input, 16: cartridge address pins (async).
- `data_in`, input, 8: cartridge data pins, input side (async).
- `nWR`, input, 1: bus write strobe, active low (async).
- `nRD`, input, 1: bus read strobe, active low (async).
- `nCS`, input, 1: bus chip-select, active low (async).
- `rom_addr`, output, `ROM_ADDR_W`: registered banked ROM byte address.
- `rom_sel`, output, 1: registered ROM read-cycle qualifier.
- `ram_enable`, output, 1: external-RAM enable register.
- `ram_bank`, output, 2: RAM bank (`bank_hi` when `mode`=1, else 0).
- `bank_mode`, output, 1: MBC1 banking mode register.
- `wr_commit`, output, 1: one-cycle pulse when a register write is applied.

## Operation

- **Synchronisers:** every bus input passes through 2 flops. Reset values: `nWR`/`nRD`/`nCS` stages = 1; `address`/`data_in` stages = 0. All logic below uses the synchronised copies only.
- **Internal registers and reset values:**
  - `bank_lo[4:0]` = 1, `bank_hi[1:0]` = 0, `mode` = 0, `ram_en` = 0.
  - FSM = IDLE, low-counter = 0.
- **Write FSM:**
  - IDLE: if `nWR`=0, go to LOW, counter = 1, capture `address` and `data_in`.
  - LOW: while `nWR`=0, re-capture `address`/`data_in` every cycle and saturate counter at `MIN_LOW`. On `nWR`=1:
    - If counter ≥ `MIN_LOW`, `nCS`=1 and captured `address[15]`=0, go to COMMIT.
    - Otherwise return to IDLE with no effect.
  - COMMIT (1 cycle): apply the write, pulse `wr_commit`, go to IDLE. A new `nWR` fall in this cycle is seen in IDLE on the next cycle.
- **Register decode** uses captured address bits [14:13]:
  - 00: `ram_en` = (`data[3:0]` == 4'hA).
  - 01: `bank_lo` = `data[4:0]`; a value of 0 is stored as 1. 0x20, 0x40 and 0x60 all store 1.
  - 10: `bank_hi` = `data[1:0]`.
  - 11: `mode` = `data[0]`.
- **ROM mapping** from the synchronised address `a`:
  - `a[14]`=0: {(`mode` ? `bank_hi` : 2'b0), 5'b0, `a[13:0]`}.
  - `a[14]`=1: {`bank_hi`, `bank_lo`, `a[13:0]`}.
  - The 21-bit result is truncated to `ROM_ADDR_W` LSBs.
- **`rom_sel`** = `~a[15]` & `~nRD` & `nWR` & `nCS`, all synchronised values.
- **Reset:** a reset mid-write (LOW or COMMIT) discards the write. All outputs are 0 on the cycle after reset, except `rom_addr`, which is 0 because the synchronised address is 0.

## Timing

- Pin change → `rom_addr`/`rom_sel` update: 3 `clk` cycles (2 sync stages + 1 output register).
- `nWR` rise at pin → `wr_commit` high: 4 cycles (2 sync, 1 LOW→COMMIT decision, 1 COMMIT). The new bank appears in `rom_addr` on the following cycle.
- The data used is the value sampled in the last synchronised-low cycle, so data is captured at the trailing edge of the write.
- `ram_enable`, `ram_bank` and `bank_mode` are direct register outputs and change in the cycle after COMMIT.
- Writes take effect one at a time; back-to-back writes need ≥1 synchronised-high cycle between them.

## Test plan

- **Reset defaults:** after `rst`, read 0x4123 → `rom_addr` = 0x04123 (bank 1), `rom_sel` = 1 after 3 cycles, `ram_enable` = 0, `bank_mode` = 0.
- **Bank select:**
  - Write 0x05 to 0x2000 (`nWR` low 40 cycles) → exactly one `wr_commit` pulse; read 0x4000 → `rom_addr` = 0x14000.
  - Write 0x00 to 0x2000 → bank 1, `rom_addr` = 0x04000.
- **Upper bits and mode:**
  - Write 0x02 to 0x4000, then 0x01 to 0x6000 → read 0x0010 gives `rom_addr` = 0x100010; `ram_bank` = 2.
  - Write 0x00 to 0x6000 → read 0x0010 gives `rom_addr` = 0x00010; `ram_bank` = 0.
- **RAM enable:** write 0x0A to 0x0000 → `ram_enable` = 1. Write 0x1B to 0x0000 → `ram_enable` = 0.
- **Glitch / ignored writes:** each of the following → no `wr_commit` and registers unchanged:
  - 2-cycle `nWR` low pulse at 0x2000.
  - Write to 0xA000.
  - Write at 0x2000 with `nCS` = 0.
- **Reset mid-write:** assert `rst` while `nWR` is low at 0x2000 with data 0x07 → no commit; `bank_lo` stays 1; FSM returns to IDLE.
